// File: rtl/ps2_host_fifo.sv
// ps2_host_fifo -- PS/2 host port with show-ahead RX FIFO.
//
// Drives an open-drain PS/2 link (lines are only ever pulled low or
// released), transmits host commands with device-ACK checking and
// receives device bytes into a show-ahead FIFO. Timings are derived
// from CLK_HZ. The input clock line is synchronised and glitch filtered.
//
// Ports:
//   clk_clk, reset_reset      system clock, async active-high reset
//   PS2_CLK, PS2_DAT          open-drain PS/2 lines (0 or Z)
//   command/_valid/_ready     command byte handshake
//   data, data_valid          FIFO head byte, FIFO non-empty
//   data_ready                pops the head when data_valid is high
//   rx_err                    pulse: parity, framing or RX timeout
//   rx_ovf                    pulse: good byte dropped, FIFO full
//   tx_done / tx_err          pulse: command ACKed / no ACK or timeout
//   data_perr                 head parity-error flag (optional)
//
// Build option: define PS2_RX_KEEP_BAD_EN to keep bad-parity bytes in
// the FIFO, tagged through the extra data_perr output.

module ps2_host_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int FIFO_AW    = 4,
    parameter int FILTER_LEN = 8,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    input  logic [7:0] command,
    input  logic       command_valid,
    output logic       command_ready,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
`ifdef PS2_RX_KEEP_BAD_EN
    output logic       data_perr,
`endif
    output logic       rx_err,
    output logic       rx_ovf,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
`ifdef PS2_RX_KEEP_BAD_EN
    localparam int DW    = 9;
`else
    localparam int DW    = 8;
`endif

    localparam longint INH_CYC = longint'(INHIBIT_US) * longint'(CLK_HZ) / 64'sd1000000;
    localparam longint TO_CYC  = longint'(TIMEOUT_US) * longint'(CLK_HZ) / 64'sd1000000;
    localparam logic [31:0] INH_M1 = 32'(INH_CYC - 1);
    localparam logic [31:0] TO_M1  = 32'(TO_CYC - 1);

    localparam int FLW = $clog2(FILTER_LEN + 1);
    localparam logic [FLW-1:0] FLT_MAX = FLW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RX, S_TX_INH, S_TX_REQ, S_TX_BITS, S_TX_ACK
    } state_t;

    state_t state, state_nx;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]     clk_sync, dat_sync;
    logic           clk_s, dat_s;
    logic           clk_f;
    logic [FLW-1:0] flt_cnt;
    logic           fall;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Filtered clock resets low so command_ready stays 0 during reset;
    // the idle-high line then brings it up as a rising (ignored) edge.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_f    <= 1'b0;
            flt_cnt  <= '0;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
            if (clk_s == clk_f) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_MAX) begin
                clk_f   <= clk_s;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // Falling edge fires on the cycle the filtered level would flip 1->0.
    assign fall = clk_f && !clk_s && (flt_cnt == FLT_MAX);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [31:0] timer;
    logic [3:0]  bit_cnt;
    logic [7:0]  rx_sh;
    logic        rx_par;
    logic [9:0]  tx_sh;
    logic        dat_low;

    logic        par_ok, stop_ok;
    logic        to_hit, cmd_acc;
    logic        rx_err_nx, rx_ovf_nx, tx_done_nx, tx_err_nx;

    logic [DW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               fifo_wr, fifo_full, pop;
    logic [DW-1:0]      wdata, head;

    assign par_ok  = ^{rx_sh, rx_par};
    assign stop_ok = dat_s;
    assign to_hit  = (timer >= TO_M1);

    assign fifo_full  = (count == CW'(DEPTH));
    assign data_valid = (count != '0);
    assign pop        = data_valid && data_ready;
    assign head       = mem[rd_ptr];

`ifdef PS2_RX_KEEP_BAD_EN
    assign wdata     = {~par_ok, rx_sh};
    assign data_perr = data_valid && head[8];
`else
    assign wdata     = rx_sh;
`endif
    assign data = data_valid ? head[7:0] : 8'h00;

    // An RX start edge in IDLE takes priority over a command accept.
    assign command_ready = (state == S_IDLE) && clk_f && !(fall && !dat_s);

    // Open-drain drivers: only ever pull low.
    assign PS2_CLK = (state == S_TX_INH) ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    // ------------------------------------------------------------------
    // FSM: next state and event pulses
    // ------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        cmd_acc    = 1'b0;
        fifo_wr    = 1'b0;
        rx_err_nx  = 1'b0;
        rx_ovf_nx  = 1'b0;
        tx_done_nx = 1'b0;
        tx_err_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall && !dat_s) begin
                    state_nx = S_RX;
                end else if (command_valid && command_ready) begin
                    cmd_acc  = 1'b1;
                    state_nx = S_TX_INH;
                end
            end
            S_RX: begin
                if (fall) begin
                    if (bit_cnt == 4'd9) begin
                        state_nx  = S_IDLE;
                        rx_err_nx = !(par_ok && stop_ok);
`ifdef PS2_RX_KEEP_BAD_EN
                        if (stop_ok) begin
`else
                        if (stop_ok && par_ok) begin
`endif
                            // A same-cycle pop frees a slot in a full FIFO.
                            if (fifo_full && !pop) rx_ovf_nx = 1'b1;
                            else                   fifo_wr   = 1'b1;
                        end
                    end
                end else if (to_hit) begin
                    state_nx  = S_IDLE;
                    rx_err_nx = 1'b1;
                end
            end
            S_TX_INH: begin
                if (timer >= INH_M1) state_nx = S_TX_REQ;
            end
            S_TX_REQ: begin
                if (fall) begin
                    state_nx = S_TX_BITS;
                end else if (to_hit) begin
                    state_nx  = S_IDLE;
                    tx_err_nx = 1'b1;
                end
            end
            S_TX_BITS: begin
                // bit_cnt reaches 10 once the stop release has been driven.
                if (fall) begin
                    if (bit_cnt == 4'd10) state_nx = S_TX_ACK;
                end else if (to_hit) begin
                    state_nx  = S_IDLE;
                    tx_err_nx = 1'b1;
                end
            end
            S_TX_ACK: begin
                if (fall) begin
                    state_nx   = S_IDLE;
                    tx_done_nx = !dat_s;
                    tx_err_nx  = dat_s;
                end else if (to_hit) begin
                    state_nx  = S_IDLE;
                    tx_err_nx = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state   <= S_IDLE;
            rx_err  <= 1'b0;
            rx_ovf  <= 1'b0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            rx_err  <= rx_err_nx;
            rx_ovf  <= rx_ovf_nx;
            tx_done <= tx_done_nx;
            tx_err  <= tx_err_nx;
        end
    end

    // ------------------------------------------------------------------
    // Shift registers, bit counter, frame timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            timer   <= '0;
            bit_cnt <= '0;
            rx_sh   <= '0;
            rx_par  <= 1'b0;
            tx_sh   <= '0;
            dat_low <= 1'b0;
        end else begin
            // The host's own clock pull in TX_INH must not restart the hold.
            if ((state != state_nx) || (state == S_IDLE) ||
                (fall && (state != S_TX_INH)))
                timer <= '0;
            else
                timer <= timer + 32'd1;

            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    if (cmd_acc) tx_sh <= {1'b1, ~^command, command};
                end
                S_RX: begin
                    if (fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt < 4'd8)       rx_sh  <= {dat_s, rx_sh[7:1]};
                        else if (bit_cnt == 4'd8) rx_par <= dat_s;
                    end
                end
                S_TX_INH: begin
                    // Start bit: data low as the clock is released.
                    if (state_nx == S_TX_REQ) dat_low <= 1'b1;
                end
                S_TX_REQ, S_TX_BITS: begin
                    if (fall && (bit_cnt != 4'd10)) begin
                        dat_low <= ~tx_sh[0];
                        tx_sh   <= {1'b1, tx_sh[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                default: ;
            endcase

            // Any return to IDLE (done, ACK, timeout) releases the data line.
            if (state_nx == S_IDLE) dat_low <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(fifo_wr) - CW'(pop);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (fifo_wr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: tb/tb_ps2_host_fifo.sv
// Bench for ps2_host_fifo: a PS/2 device model on pulled-up lines,
// a vector table of RX frames, a scoreboard of expected FIFO bytes,
// and hand sequences for overflow, transmit, timeout and mid-frame reset.

module tb_ps2_host_fifo;

    localparam int HALF = 20;  // device half clock period in system cycles
`ifdef PS2_RX_KEEP_BAD_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic [7:0] command;
    logic       command_valid;
    logic       command_ready;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
`ifdef PS2_RX_KEEP_BAD_EN
    logic       data_perr;
`endif
    logic       rx_err, rx_ovf, tx_done, tx_err;

    wire  ps2_clk, ps2_dat;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    ps2_host_fifo #(
        .CLK_HZ(1000000), .FIFO_AW(4), .FILTER_LEN(8),
        .INHIBIT_US(120), .TIMEOUT_US(2000)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .command(command), .command_valid(command_valid), .command_ready(command_ready),
        .data(data), .data_valid(data_valid), .data_ready(data_ready),
`ifdef PS2_RX_KEEP_BAD_EN
        .data_perr(data_perr),
`endif
        .rx_err(rx_err), .rx_ovf(rx_ovf), .tx_done(tx_done), .tx_err(tx_err)
    );

    always #5 clk_clk = ~clk_clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, acc_cyc = 0;
    int c_rx_err = 0, c_rx_ovf = 0, c_tx_done = 0, c_tx_err = 0;
    logic [8:0] sb[$];  // {perr, byte}

    always @(posedge clk_clk) cyc++;
    always @(negedge clk_clk) begin
        if (rx_err)  c_rx_err++;
        if (rx_ovf)  c_rx_ovf++;
        if (tx_done) c_tx_done++;
        if (tx_err)  c_tx_err++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // Device-to-host frame; nbits < 11 truncates it (device stops clocking).
    task automatic dev_send(input logic [7:0] d, input bit par_flip, input bit stop, input int nbits);
        logic [10:0] f;
        f = {stop, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_dat_low = ~f[i];
            tick(HALF);
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
        end
        dev_dat_low = 1'b0;
        tick(2 * HALF);
    endtask

    // Pop everything, comparing against the scoreboard.
    task automatic drain(input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_clk);
            if (!data_valid) break;
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                check("rx_data", data, sb[0][7:0]);
`ifdef PS2_RX_KEEP_BAD_EN
                check("rx_perr", data_perr, sb[0][8]);
`endif
                void'(sb.pop_front());
            end
            data_ready = 1'b1;
            @(negedge clk_clk);
            data_ready = 1'b0;
            n++;
        end
        check("pop_count", n, exp_n);
        check("empty_after_drain", data_valid, 0);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        int t;
        t = 0;
        while (!command_ready && t < 500) begin
            @(negedge clk_clk);
            t++;
        end
        check("cmd_ready_before", command_ready, 1);
        command = c;
        command_valid = 1'b1;
        @(posedge clk_clk);
        #1;
        acc_cyc = cyc;
        command_valid = 1'b0;
        check("cmd_ready_drops", command_ready, 0);
    endtask

    // Host-to-device receiver: measures the inhibit, clocks 12 pulses,
    // samples each bit while the clock is high, optionally ACKs.
    task automatic dev_rx(input bit ack_low, output logic [10:0] seen, output int low_cyc);
        seen = '0;
        for (int t = 0; t < 1000 && ps2_clk === 1'b0; t++) begin
            @(posedge clk_clk);
            #1;
        end
        low_cyc = cyc - acc_cyc;
        tick(HALF);
        seen[0] = ps2_dat;
        for (int k = 1; k <= 12; k++) begin
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
            tick(HALF);
            if (k <= 10) seen[k] = ps2_dat;
            if (k == 10 && ack_low) dev_dat_low = 1'b1;
        end
        dev_dat_low = 1'b0;
        tick(HALF);
    endtask

    typedef struct {
        logic [7:0] d;
        bit par_flip;
        bit stop;
        bit store;
        bit perr;
        bit err;
    } rx_vec_t;

    rx_vec_t vec[6];

    initial begin
        int e0, o0, d0, x0, low;
        logic [10:0] seen;

        vec[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[1] = '{8'hAA, 1'b1, 1'b1, KEEP, 1'b1, 1'b1};
        vec[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        reset_reset = 1'b1;
        command = 8'h00;
        command_valid = 1'b0;
        data_ready = 1'b0;

        // Reset state
        tick(5);
        check("rst_ready", command_ready, 0);
        check("rst_valid", data_valid, 0);
        check("rst_data", data, 0);
        check("rst_pulses", {rx_err, rx_ovf, tx_done, tx_err}, 0);
        check("rst_lines", {ps2_clk, ps2_dat}, 2'b11);
        reset_reset = 1'b0;
        tick(20);
        check("ready_after_rst", command_ready, 1);

        // Vector table of RX frames
        for (int i = 0; i < 6; i++) begin
            e0 = c_rx_err;
            o0 = c_rx_ovf;
            if (vec[i].store) sb.push_back({vec[i].perr, vec[i].d});
            dev_send(vec[i].d, vec[i].par_flip, vec[i].stop, 11);
            check($sformatf("rx_err[%0d]", i), c_rx_err - e0, vec[i].err);
            check($sformatf("rx_ovf[%0d]", i), c_rx_ovf - o0, 0);
            drain(vec[i].store ? 1 : 0);
        end

        // 17 bytes into a 16-deep FIFO
        e0 = c_rx_err;
        o0 = c_rx_ovf;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back({1'b0, 8'h30 + 8'(i)});
            dev_send(8'h30 + 8'(i), 1'b0, 1'b1, 11);
        end
        check("ovf_pulse", c_rx_ovf - o0, 1);
        check("ovf_no_err", c_rx_err - e0, 0);
        drain(16);

        // Transmit 0xED with ACK
        d0 = c_tx_done;
        x0 = c_tx_err;
        send_cmd(8'hED);
        dev_rx(1'b1, seen, low);
        check("inhibit_ge_120", low >= 120, 1);
        check("tx_bits", seen, {2'b11, 8'hED, 1'b0});
        check("tx_done", c_tx_done - d0, 1);
        check("tx_no_err", c_tx_err - x0, 0);
        tick(5);
        check("ready_after_tx", command_ready, 1);

        // Transmit without ACK
        d0 = c_tx_done;
        x0 = c_tx_err;
        send_cmd(8'h01);
        dev_rx(1'b0, seen, low);
        check("tx_bits_01", seen, {2'b10, 8'h01, 1'b0});
        check("noack_err", c_tx_err - x0, 1);
        check("noack_done", c_tx_done - d0, 0);

        // RX timeout after 4 data bits, then a good frame
        e0 = c_rx_err;
        dev_send(8'h5A, 1'b0, 1'b1, 5);
        tick(2100);
        check("rx_timeout_err", c_rx_err - e0, 1);
        check("idle_after_to", command_ready, 1);
        sb.push_back({1'b0, 8'h3A});
        dev_send(8'h3A, 1'b0, 1'b1, 11);
        drain(1);

        // Reset during TX_BITS, with a byte left in the FIFO
        dev_send(8'h42, 1'b0, 1'b1, 11);
        check("fifo_loaded", data_valid, 1);
        send_cmd(8'h00);
        for (int t = 0; t < 1000 && ps2_clk === 1'b0; t++) tick(1);
        tick(HALF);
        for (int k = 0; k < 3; k++) begin
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
            tick(HALF);
        end
        check("dat_driven_in_tx", ps2_dat, 0);
        reset_reset = 1'b1;
        #1;
        check("mid_rst_lines", {ps2_clk, ps2_dat}, 2'b11);
        check("mid_rst_outs", {command_ready, data_valid, rx_err, rx_ovf, tx_done, tx_err}, 0);
        check("mid_rst_data", data, 0);
        sb.delete();
        tick(3);
        reset_reset = 1'b0;
        tick(20);
        check("ready_after_mid_rst", command_ready, 1);
        check("fifo_empty_after_rst", data_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
